// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high gfedcba glyphs, special BCD codes
// and the scan-reader FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the 7-segment encoder: active-high gfedcba in,
// BCD code out; an all-dark pattern is blank, anything unknown is an error.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  always_comb begin
    o_bcd = BCD_ERR;
    o_err = 1'b1;
    case (i_seg)
      SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
      SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
      SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
      SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
      SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
      SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
      SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
      SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
      SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
      SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
      7'b0000000: begin o_bcd = BCD_BLANK; o_err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus and rebuilds per-digit BCD.
// Define SEG7_READER_STALE_EN to invalidate digits not refreshed within STALE_CYCLES.
//
// state  | meaning
// IDLE   | no single digit enabled; waiting for a one-hot enable
// SETTLE | counting identical samples of the latched digit/pattern
// HOLD   | pattern captured; waiting for a change before recapturing
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int STALE_CYCLES  = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  input  logic                    err_clr
);

  localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);

  logic [6:0]              r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2;
  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_pat;
  logic [7:0]              r_cnt;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_valid, r_mask;
  logic                    r_frame_done, r_err;

  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an, w_cap_bit, w_expire;
  logic                    w_onehot, w_change, w_capture, w_dec_err;
  logic [IDX_W-1:0]        w_idx;
  logic [7:0]              w_cnt_inc;
  logic [3:0]              w_dec_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
    end
  end

  always_comb begin
    w_seg    = ~r_seg_s2;
    w_an     = ~r_an_s2;
    w_onehot = (w_an != '0) && ((w_an & (w_an - NUM_DIGITS'(1))) == '0);
    w_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an[i]) w_idx = IDX_W'(i);
    end
    w_change  = (w_idx != r_idx) || (w_seg != r_pat);
    w_cnt_inc = (r_cnt >= SETTLE_L) ? SETTLE_L : r_cnt + 8'd1;
    w_capture = (r_state == ST_SETTLE) && w_onehot && !w_change && (w_cnt_inc == SETTLE_L);
    w_cap_bit = '0;
    if (w_capture) w_cap_bit[r_idx] = 1'b1;
  end

  seg7_to_bcd u_dec (
    .i_seg (r_pat),
    .o_bcd (w_dec_bcd),
    .o_err (w_dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_onehot) begin
            r_idx   <= w_idx;
            r_pat   <= w_seg;
            r_cnt   <= 8'd1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE, ST_HOLD: begin
          if (!w_onehot) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (w_change) begin
            r_idx   <= w_idx;
            r_pat   <= w_seg;
            r_cnt   <= 8'd1;
            r_state <= ST_SETTLE;
          end else if (r_state == ST_SETTLE) begin
            r_cnt <= w_cnt_inc;
            if (w_capture) r_state <= ST_HOLD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEG7_READER_STALE_EN
  localparam int                   STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0]   STALE_L = STALE_W'(STALE_CYCLES - 1);
  logic [STALE_W-1:0]              r_stale [NUM_DIGITS];

  always_comb begin
    w_expire = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_expire[i] = r_valid[i] && (r_stale[i] == STALE_L) && !w_cap_bit[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_stale[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_bit[i] || w_expire[i]) r_stale[i] <= '0;
        else if (r_valid[i])             r_stale[i] <= r_stale[i] + 1'b1;
      end
    end
  end
`else
  assign w_expire = '0;
`endif

  // A capture landing on the mask-clear cycle seeds the next frame's mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd        <= {NUM_DIGITS{BCD_BLANK}};
      r_valid      <= '0;
      r_mask       <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= &r_mask;
      r_mask       <= ((&r_mask) ? '0 : r_mask) | w_cap_bit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_bit[i]) begin
          r_bcd[4*i +: 4] <= w_dec_bcd;
          r_valid[i]      <= 1'b1;
        end else if (w_expire[i]) begin
          r_bcd[4*i +: 4] <= BCD_BLANK;
          r_valid[i]      <= 1'b0;
        end
      end
      if (w_capture && w_dec_err) r_err <= 1'b1;
      else if (err_clr)           r_err <= 1'b0;
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign pattern_err = r_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus random scan
// traffic checked against a run-length model of the display.
module tb_seg7_scan_reader;

  localparam int ND  = 4;
  localparam int SC  = 8;
  localparam int STC = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          err_clr;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          pattern_err;

  seg7_scan_reader #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (SC),
    .STALE_CYCLES  (STC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;

  logic [15:0] m_bcd;
  logic [3:0]  m_valid, m_mask;
  logic        m_err;
  int          m_frames = 0;
  int          prev_idx;
  logic [6:0]  prev_pat;
  int          run_len;

  logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(negedge clk) if (frame_done === 1'b1) n_frames++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (pat_tbl[d] == p) return 4'(d);
    if (p == 7'd0) return 4'hF;
    return 4'hE;
  endfunction

  task automatic model_reset();
    m_bcd    = 16'hFFFF;
    m_valid  = '0;
    m_mask   = '0;
    m_err    = 1'b0;
    prev_idx = -1;
    prev_pat = '0;
    run_len  = 0;
  endtask

  task automatic model_capture(input int idx, input logic [6:0] pat);
    logic [3:0] d;
    d = ref_decode(pat);
    m_bcd[4*idx +: 4] = d;
    m_valid[idx] = 1'b1;
    if (d == 4'hE) m_err = 1'b1;
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin
      m_frames++;
      m_mask = '0;
    end
  endtask

  // A digit is captured once per uninterrupted run of SC identical samples.
  task automatic drive_slot(input int idx, input logic [6:0] pat, input int len);
    int prev_run;
    an_n  = ~(4'b0001 << idx);
    seg_n = ~pat;
    if (idx == prev_idx && pat == prev_pat) begin
      prev_run = run_len;
      run_len  = run_len + len;
    end else begin
      prev_run = 0;
      run_len  = len;
    end
    prev_idx = idx;
    prev_pat = pat;
    if (prev_run < SC && run_len >= SC) model_capture(idx, pat);
    repeat (len) @(negedge clk);
  endtask

  task automatic drive_idle(input int len, input logic [3:0] an);
    an_n     = an;
    seg_n    = 7'($urandom);
    prev_idx = -1;
    repeat (len) @(negedge clk);
  endtask

  function automatic logic [3:0] multi_hot();
    int a, b;
    logic [3:0] v;
    a = $urandom_range(0, 3);
    b = (a + $urandom_range(1, 3)) % 4;
    v = 4'($urandom);
    v[a] = 1'b0;
    v[b] = 1'b0;
    return v;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_bcd"},    bcd_out,     m_bcd);
    chk({tag, "_valid"},  digit_valid, m_valid);
    chk({tag, "_err"},    pattern_err, m_err);
    chk({tag, "_frames"}, n_frames,    m_frames);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int         nslots, len, sel, idx, kind;
  logic [6:0] pat;

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    an_n    = '1;
    seg_n   = '1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_bcd",   bcd_out,     16'hFFFF);
    chk("rst_valid", digit_valid, 4'h0);
    chk("rst_frame", frame_done,  1'b0);
    chk("rst_err",   pattern_err, 1'b0);
    rst_n = 1'b1;

    // digits 3,1,4,1
    drive_slot(0, pat_tbl[3], 20);
    drive_slot(1, pat_tbl[1], 20);
    drive_slot(2, pat_tbl[4], 20);
    drive_slot(3, pat_tbl[1], 20);
    drive_idle(8, 4'hF);
    chk("frame_bcd",    bcd_out,     16'h1413);
    chk("frame_valid",  digit_valid, 4'hF);
    chk("frame_pulses", n_frames,    1);
    check_state("frame");

    // short "8" glitch inside a "5" slot on digit 1
    drive_slot(1, pat_tbl[5], 4);
    drive_slot(1, pat_tbl[8], 3);
    drive_slot(1, pat_tbl[5], 4);
    chk("glitch_mid", bcd_out[7:4], 4'd1);
    drive_slot(1, pat_tbl[5], 9);
    drive_idle(8, 4'hF);
    chk("glitch_d1", bcd_out[7:4], 4'd5);
    check_state("glitch");

    // undecodable pattern, then clear
    drive_slot(0, 7'b1010101, 20);
    drive_idle(8, 4'hF);
    chk("perr_code", bcd_out[3:0], 4'hE);
    chk("perr_flag", pattern_err,  1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("perr_clr", pattern_err, 1'b0);

    // two digits enabled at once
    drive_idle(50, 4'b1100);
    check_state("multi");

    // asynchronous reset while settling
    an_n  = 4'b1011;
    seg_n = ~pat_tbl[7];
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd",   bcd_out,     16'hFFFF);
    chk("arst_valid", digit_valid, 4'h0);
    chk("arst_frame", frame_done,  1'b0);
    chk("arst_err",   pattern_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < ND; i++) drive_slot(i, pat_tbl[$urandom_range(0, 9)], 15);
    drive_idle(8, 4'hF);
    chk("rfrm_valid", digit_valid, 4'hF);
    check_state("rfrm");

`ifdef SEG7_READER_STALE_EN
    do_reset();
    drive_slot(0, pat_tbl[2], 15);
    drive_slot(1, pat_tbl[6], 15);
    drive_slot(2, pat_tbl[9], 15);
    drive_slot(3, pat_tbl[0], 15);
    repeat (25) begin
      drive_slot(0, pat_tbl[2], 12);
      drive_slot(1, pat_tbl[6], 12);
      drive_slot(3, pat_tbl[0], 12);
    end
    drive_idle(8, 4'hF);
    m_valid[2]     = 1'b0;
    m_bcd[11:8]    = 4'hF;
    chk("stale_v2", digit_valid[2], 1'b0);
    chk("stale_b2", bcd_out[11:8],  4'hF);
    check_state("stale");
`endif

    for (int it = 0; it < 40; it++) begin
`ifdef SEG7_READER_STALE_EN
      do_reset();
`endif
      nslots = $urandom_range(1, 6);
      for (int s = 0; s < nslots; s++) begin
        len = $urandom_range(1, 20);
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
          drive_idle(len, multi_hot());
        end else if (sel == 1 && prev_idx >= 0) begin
          drive_slot(prev_idx, prev_pat, len);
        end else begin
          idx  = $urandom_range(0, 3);
          kind = $urandom_range(0, 9);
          if (kind < 7)       pat = pat_tbl[$urandom_range(0, 9)];
          else if (kind == 7) pat = 7'd0;
          else                pat = 7'($urandom);
          drive_slot(idx, pat, len);
        end
      end
      drive_idle(8, 4'hF);
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
      end
      check_state($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
